// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EXE hazard controller and its mul/div sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int MD_CNT_W = 4;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF      = 2'd0;
  localparam fwd_sel_t FWD_EXE     = 2'd1;
  localparam fwd_sel_t FWD_MEM_ALU = 2'd2;
  localparam fwd_sel_t FWD_MEM_LD  = 2'd3;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy sequencer for a multi-cycle mul/div: busy stays high for MD_LAT-1
// cycles after the issuing edge, so the op holds EXE for MD_LAT cycles in total.
module md_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic hold,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LAT - 1);

  md_state_t           state;
  logic [MD_CNT_W-1:0] md_cnt;

  // With MD_LAT=1 the load value is zero and the op never leaves IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (load && (LOAD_VAL != '0)) begin
            state  <= MD_BUSY;
            md_cnt <= LOAD_VAL;
            busy   <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (hold) begin
            md_cnt <= md_cnt - 1'b1;
            if (md_cnt == MD_CNT_W'(1)) begin
              state <= MD_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= MD_IDLE;
          md_cnt <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the ID/EXE register: shadow EXE/MEM scoreboard, load-use
// stall/bubble, mul/div hold and operand forwarding selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] drs,
  input  logic [4:0] drt,
  input  logic       duse_rs,
  input  logic       duse_rt,
  input  logic       dwreg,
  input  logic       dm2reg,
  input  logic [4:0] drn,
  input  logic       dmuldiv,
  output logic       fstall,
  output logic       dbubble,
  output logic       ehold,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       ebusy
);

  logic     e_wreg, e_m2reg, m_wreg, m_m2reg;
  reg_idx_t e_rn, m_rn;
  logic     lu, md_load, busy;

  function automatic fwd_sel_t fwd_pick(input reg_idx_t src,
                                        input logic ew, input logic em, input reg_idx_t ern,
                                        input logic mw, input logic mm, input reg_idx_t mrn);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ew && !em && (ern != '0) && (ern == src))
      sel = FWD_EXE;
    else if (mw && (mrn != '0) && (mrn == src))
      sel = mm ? FWD_MEM_LD : FWD_MEM_ALU;
    return sel;
  endfunction

  assign lu = e_wreg && e_m2reg && (e_rn != '0) &&
              ((duse_rs && (e_rn == drs)) || (duse_rt && (e_rn == drt)));

  assign ehold   = busy;
  assign ebusy   = busy;
  assign fstall  = ehold | lu;
  assign dbubble = lu & ~ehold;
  assign fwda    = fwd_pick(drs, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);
  assign fwdb    = fwd_pick(drt, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);

  // A mul/div only issues when ID actually advances into EXE.
  assign md_load = dmuldiv & ~ehold & ~dbubble;

  md_busy_counter #(.MD_LAT(MD_LAT)) u_md_busy (
    .clock (clock),
    .reset (reset),
    .load  (md_load),
    .hold  (ehold),
    .busy  (busy)
  );

  // EXE/MEM shadow scoreboard
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_rn    <= '0;
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
      m_rn    <= '0;
    end else if (ehold) begin
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
    end else if (dbubble) begin
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_rn    <= e_rn;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_rn    <= '0;
    end else begin
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_rn    <= e_rn;
      e_wreg  <= dwreg;
      e_m2reg <= dm2reg;
      e_rn    <= drn;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT=4): inputs change on the falling
// edge, combinational outputs are checked mid-low-phase before the next rising edge.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] drs, drt, drn;
  logic       duse_rs, duse_rt, dwreg, dm2reg, dmuldiv;
  logic       fstall, dbubble, ehold, ebusy;
  logic [1:0] fwda, fwdb;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MD_LAT(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .drs     (drs),
    .drt     (drt),
    .duse_rs (duse_rs),
    .duse_rt (duse_rt),
    .dwreg   (dwreg),
    .dm2reg  (dm2reg),
    .drn     (drn),
    .dmuldiv (dmuldiv),
    .fstall  (fstall),
    .dbubble (dbubble),
    .ehold   (ehold),
    .fwda    (fwda),
    .fwdb    (fwdb),
    .ebusy   (ebusy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setid(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic wr, input logic ld,
                       input logic [4:0] rn, input logic md);
    drs = rs; drt = rt; duse_rs = urs; duse_rt = urt;
    dwreg = wr; dm2reg = ld; drn = rn; dmuldiv = md;
  endtask

  // Advance one cycle; returns just after the falling edge with outputs settled.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    chk("rst_fstall", {3'b0, fstall}, 4'd0);
    chk("rst_dbubble", {3'b0, dbubble}, 4'd0);
    chk("rst_ehold", {3'b0, ehold}, 4'd0);
    chk("rst_ebusy", {3'b0, ebusy}, 4'd0);
    chk("rst_fwda", {2'b0, fwda}, 4'd0);
    chk("rst_fwdb", {2'b0, fwdb}, 4'd0);
    @(negedge clock);
    reset = 1'b0;

    // Load-use: load $5, then reader of $5
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    #1;
    chk("lu_pre_fstall", {3'b0, fstall}, 4'd0);
    cyc();
    setid(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0);
    #1;
    chk("lu_fstall", {3'b0, fstall}, 4'd1);
    chk("lu_dbubble", {3'b0, dbubble}, 4'd1);
    chk("lu_fwda_wait", {2'b0, fwda}, 4'd0);
    cyc();
    chk("lu_after_fstall", {3'b0, fstall}, 4'd0);
    chk("lu_after_dbubble", {3'b0, dbubble}, 4'd0);
    chk("lu_after_fwda", {2'b0, fwda}, 4'd3);

    // ALU chain on $3
    cyc();
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    #1;
    chk("alu_fwda_r0", {2'b0, fwda}, 4'd0);
    cyc();
    setid(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("alu_fwda_exe", {2'b0, fwda}, 4'd1);
    chk("alu_fwdb_exe", {2'b0, fwdb}, 4'd1);
    chk("alu_fstall", {3'b0, fstall}, 4'd0);
    cyc();
    chk("alu_fwda_mem", {2'b0, fwda}, 4'd2);
    chk("alu_fwdb_mem", {2'b0, fwdb}, 4'd2);

    // Register zero: load to $0, then reader of $0
    cyc();
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    cyc();
    setid(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("r0_fstall", {3'b0, fstall}, 4'd0);
    chk("r0_dbubble", {3'b0, dbubble}, 4'd0);
    chk("r0_fwda", {2'b0, fwda}, 4'd0);

    // Mul/div to $7, dependent reader waits in ID
    cyc();
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1);
    #1;
    chk("md_issue_ebusy", {3'b0, ebusy}, 4'd0);
    cyc();
    setid(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("md_ehold_%0d", i), {3'b0, ehold}, 4'd1);
      chk($sformatf("md_fstall_%0d", i), {3'b0, fstall}, 4'd1);
      chk($sformatf("md_ebusy_%0d", i), {3'b0, ebusy}, 4'd1);
      chk($sformatf("md_dbubble_%0d", i), {3'b0, dbubble}, 4'd0);
      cyc();
    end
    chk("md_done_ehold", {3'b0, ehold}, 4'd0);
    chk("md_done_fstall", {3'b0, fstall}, 4'd0);
    chk("md_done_fwda", {2'b0, fwda}, 4'd1);
    cyc();
    chk("md_mem_fwda", {2'b0, fwda}, 4'd2);

    // Reset in the second busy cycle of a mul/div to $8
    cyc();
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1);
    cyc();
    setid(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rb_busy1_ehold", {3'b0, ehold}, 4'd1);
    cyc();
    chk("rb_busy2_ehold", {3'b0, ehold}, 4'd1);
    chk("rb_busy2_fwda", {2'b0, fwda}, 4'd1);
    reset = 1'b1;
    #1;
    chk("rb_async_ehold", {3'b0, ehold}, 4'd0);
    chk("rb_async_fwda", {2'b0, fwda}, 4'd0);
    chk("rb_async_fstall", {3'b0, fstall}, 4'd0);
    @(negedge clock);
    reset = 1'b0;

    // Normal issue after reset, then back-to-back mul/div
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1);
    #1;
    chk("b2b_first_ehold", {3'b0, ehold}, 4'd0);
    cyc();
    setid(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("b2b_hold_%0d", i), {3'b0, ehold}, 4'd1);
      cyc();
    end
    chk("b2b_fall_ehold", {3'b0, ehold}, 4'd0);
    chk("b2b_fall_fwda", {2'b0, fwda}, 4'd1);
    cyc();
    chk("b2b_second_ehold", {3'b0, ehold}, 4'd1);
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cyc();
    cyc();
    cyc();
    chk("b2b_drain_ehold", {3'b0, ehold}, 4'd0);

    // Mul/div with a load-use hazard: bubble first, issue one cycle later
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0);
    cyc();
    setid(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 1'b1);
    #1;
    chk("mdlu_dbubble", {3'b0, dbubble}, 4'd1);
    chk("mdlu_fstall", {3'b0, fstall}, 4'd1);
    chk("mdlu_ehold", {3'b0, ehold}, 4'd0);
    cyc();
    chk("mdlu_next_dbubble", {3'b0, dbubble}, 4'd0);
    chk("mdlu_next_fwda", {2'b0, fwda}, 4'd3);
    cyc();
    chk("mdlu_issued_ehold", {3'b0, ehold}, 4'd1);
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cyc();
    cyc();
    cyc();
    chk("mdlu_drain_ehold", {3'b0, ehold}, 4'd0);

    // Load-use hazard while ehold is high: hold wins, bubble after ehold falls
    setid(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 1'b1);
    cyc();
    setid(5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pri_dbubble_%0d", i), {3'b0, dbubble}, 4'd0);
      chk($sformatf("pri_fstall_%0d", i), {3'b0, fstall}, 4'd1);
      cyc();
    end
    chk("pri_fall_ehold", {3'b0, ehold}, 4'd0);
    chk("pri_fall_dbubble", {3'b0, dbubble}, 4'd1);
    chk("pri_fall_fstall", {3'b0, fstall}, 4'd1);
    cyc();
    chk("pri_after_dbubble", {3'b0, dbubble}, 4'd0);
    chk("pri_after_fstall", {3'b0, fstall}, 4'd0);
    chk("pri_after_fwda", {2'b0, fwda}, 4'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the ID/EXE pipeline register of the five-stage CPU. It keeps a shadow scoreboard of the destination, write-enable and load flags held in the EXE and MEM stages. From that state it drives stall, bubble and hold controls for the IF/ID and ID/EXE registers, and the forwarding selects for the two ID-stage operands. It also sequences a multi-cycle multiply/divide operation that occupies EXE for `MD_LAT` cycles.

## Interface
- `MD_LAT`, 4, cycles a mul/div instruction occupies EXE, range 1..15
- `clock`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `drs`  in  5  ID source register rs
- `drt`  in  5  ID source register rt
- `duse_rs`  in  1  ID instruction reads rs
- `duse_rt`  in  1  ID instruction reads rt
- `dwreg`  in  1  ID instruction writes register file
- `dm2reg`  in  1  ID instruction is a load
- `drn`  in  5  ID destination register
- `dmuldiv`  in  1  ID instruction is a multi-cycle mul/div
- `fstall`  out  1  hold PC and IF/ID register
- `dbubble`  out  1  load ID/EXE with a bubble (all write/mem controls 0)
- `ehold`  out  1  hold ID/EXE contents unchanged
- `fwda`  out  2  rs operand select
- `fwdb`  out  2  rt operand select
- `ebusy`  out  1  mul/div still occupying EXE

Forwarding select encodings are the same for `fwda` and `fwdb`:
- 0: register file
- 1: EXE ALU result
- 2: MEM ALU result
- 3: MEM load data

## Operation
- Shadow state: `e_wreg`, `e_m2reg`, `e_rn`, `m_wreg`, `m_m2reg`, `m_rn`, and a 4-bit counter `md_cnt`.
- Load-use hazard (`lu`): `e_wreg & e_m2reg & e_rn!=0` and either `(duse_rs & e_rn==drs)` or `(duse_rt & e_rn==drt)`.
- Outputs, all combinational from shadow state and ID inputs:
  - `ehold = ebusy = (md_cnt!=0)`
  - `fstall = ehold | lu`
  - `dbubble = lu & ~ehold`; `ehold` has priority over `dbubble`.
- `fwda` priority:
  - 1 when `e_wreg & ~e_m2reg & e_rn!=0 & e_rn==drs`;
  - else `m_m2reg ? 3 : 2` when `m_wreg & m_rn!=0 & m_rn==drs`;
  - else 0.
  - `fwdb` uses identical logic on `drt`.
  - The selects are not gated by `duse_*`. The consumer ignores unused operands.
  - Register 0 never forwards.
- Shadow update, per clock edge, in priority order:
  - `ehold`: E shadow unchanged; M shadow receives a bubble (`m_wreg=0`, `m_m2reg=0`); `md_cnt` decrements.
  - `dbubble`: M shadow gets E shadow; E shadow gets a bubble (`e_wreg=0`, `e_m2reg=0`, `e_rn=0`).
  - Otherwise: M gets E; E gets the ID inputs. If `dmuldiv`, `md_cnt` loads `MD_LAT-1`.
- Mul/div state machine:
  - IDLE (`md_cnt==0`) moves to BUSY on issue of `dmuldiv`, only when `MD_LAT>1`.
  - BUSY decrements `md_cnt` to 0, then returns to IDLE.
  - With `MD_LAT=1`, mul/div behaves as a single-cycle op.
- Its result forwards from EXE (select 1) on the last occupied cycle. It is a non-load writer.

## Timing
- Reset, asynchronous: all shadow bits 0 and `md_cnt=0`. Outputs after reset: `fstall=0`, `dbubble=0`, `ehold=0`, `ebusy=0`, `fwda=0`, `fwdb=0`.
- Load-use costs exactly 1 stall cycle. On the next cycle the load sits in MEM and the consumer receives select 3.
- Mul/div occupies EXE for exactly `MD_LAT` cycles. `ehold` and `fstall` are high for `MD_LAT-1` cycles starting the cycle after issue.
- Simultaneous events:
  - `dmuldiv` with `lu` true: the bubble wins and the mul/div issues a cycle later.
  - `lu` while `ehold` is high: no bubble. The ID instruction is re-evaluated once `ehold` falls.
- Reset asserted mid-BUSY clears `md_cnt` immediately. `ehold` drops with no clock edge needed.
- Back-to-back mul/div: the second issues the cycle `ehold` falls. There is no extra gap cycle.

## Structure
- Shared package holds:
  - forwarding select constants (`FWD_RF`, `FWD_EXE`, `FWD_MEM_ALU`, `FWD_MEM_LD`);
  - a 5-bit register-index typedef;
  - an `MD_CNT_W=4` constant.
- One sub-module is natural: `md_busy_counter`.
  - Inputs: load, hold-decrement.
  - Outputs: `busy`.
  - It is parameterised by `MD_LAT`.
- Scoreboard and compare logic stay in the top-level module.

## Test plan
- Load-use:
  - Stimulus: load `$5` in ID (`dwreg=1`, `dm2reg=1`, `drn=5`); next cycle ID has `drs=5`, `duse_rs=1`.
  - Required: `fstall=1` and `dbubble=1` for one cycle; then `fwda=3`, `fstall=0`.
- ALU chain:
  - Stimulus: ALU write `$3`, then an instruction reading `$3` via rs and rt.
  - Required: `fwda=1`, `fwdb=1`. One instruction later (same reg still in M only): `fwda=2`.
- Register zero:
  - Stimulus: `drn=0` load followed by a reader of `$0`.
  - Required: no stall; `fwda=0`.
- Mul/div with `MD_LAT=4`:
  - Stimulus: issue `dmuldiv`.
  - Required: `ehold`, `fstall` and `ebusy` high for exactly 3 cycles; M shadow shows bubbles; a dependent reader then gets `fwda=1`.
- Reset during BUSY:
  - Stimulus: assert `reset` in the second busy cycle.
  - Required: `ehold=0` and `fwda=0` asynchronously; after deassert, normal issue resumes.
- Priority:
  - Stimulus: present `lu` while `md_cnt!=0`.
  - Required: `dbubble=0`, `fstall=1`; the bubble is inserted the cycle after `ehold` falls if the hazard persists.
